// File: rtl/vec_regfile_sb_if.sv
// rtl/vec_regfile_sb_if.sv - decoder/writeback bus of the vector register file
// Master is the decode/writeback side, slave is the register file.
interface vec_regfile_sb_if #(
   parameter int LANES  = 4,
   parameter int LANE_W = 32,
   parameter int ADDR_W = 5
);
   localparam int VW = LANES * LANE_W;

   logic              WriteEn;
   logic [ADDR_W-1:0] rd;
   logic [LANES-1:0]  WriteMask;
   logic [VW-1:0]     InputData;
   logic              IssueEn;
   logic [ADDR_W-1:0] IssueRd;
   logic [ADDR_W-1:0] Rs1;
   logic [ADDR_W-1:0] Rs2;
   logic [VW-1:0]     Rout1;
   logic [VW-1:0]     Rout2;
   logic              Pending1;
   logic              Pending2;
   logic              Busy;

   modport master (
      output WriteEn, rd, WriteMask, InputData, IssueEn, IssueRd, Rs1, Rs2,
      input  Rout1, Rout2, Pending1, Pending2, Busy
   );

   modport slave (
      input  WriteEn, rd, WriteMask, InputData, IssueEn, IssueRd, Rs1, Rs2,
      output Rout1, Rout2, Pending1, Pending2, Busy
   );
endinterface

// File: rtl/vec_regfile_sb.sv
// rtl/vec_regfile_sb.sv - vector register file with lane masks, forwarding and pending scoreboard
// Registers are zeroed one per cycle after reset; reads and the scoreboard are blanked meanwhile.
module vec_regfile_sb #(
   parameter int NUM_REGS = 8,
   parameter int LANES    = 4,
   parameter int LANE_W   = 32,
   parameter int ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   vec_regfile_sb_if.slave   bus
);
   localparam int VW    = LANES * LANE_W;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic {CLEAR, READY} state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic               busy_q;

   logic [VW-1:0]       regs_q [NUM_REGS];
   logic [VW-1:0]       regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_d;

   logic               ready;
   logic               wr_ok;
   logic               iss_ok;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   iss_idx;

   logic [ADDR_W-1:0]  rs_c   [2];
   logic [VW-1:0]      rout_c [2];
   logic               pend_c [2];

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS));
   endfunction

   assign ready   = (state_q == READY);
   assign wr_ok   = ready && !rst && bus.WriteEn && in_range(bus.rd);
   assign iss_ok  = ready && !rst && bus.IssueEn && in_range(bus.IssueRd);
   assign wr_idx  = bus.rd[IDX_W-1:0];
   assign iss_idx = bus.IssueRd[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         idx_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
                  idx_q   <= '0;
               end
            end
            READY: begin
               state_q <= READY;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= CLEAR;
               idx_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // Storage is left alone on a reset edge; the clear walk zeroes it afterwards.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
      end
      if (!rst && state_q == CLEAR) begin
         regs_d[idx_q] = '0;
      end
      if (wr_ok) begin
         for (int l = 0; l < LANES; l++) begin
            if (bus.WriteMask[l]) begin
               regs_d[wr_idx][l*LANE_W +: LANE_W] = bus.InputData[l*LANE_W +: LANE_W];
            end
         end
      end
   end

   // Issue is applied after the write so a new producer keeps the bit set.
   always_comb begin
      pend_d = pend_q;
      if (wr_ok) begin
         pend_d[wr_idx] = 1'b0;
      end
      if (iss_ok) begin
         pend_d[iss_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign rs_c[0] = bus.Rs1;
   assign rs_c[1] = bus.Rs2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rout_c[p] = '0;
         pend_c[p] = 1'b0;
         if (ready && in_range(rs_c[p])) begin
            rout_c[p] = regs_q[rs_c[p][IDX_W-1:0]];
            pend_c[p] = pend_q[rs_c[p][IDX_W-1:0]];
            if (bus.WriteEn && bus.rd == rs_c[p]) begin
               for (int l = 0; l < LANES; l++) begin
                  if (bus.WriteMask[l]) begin
                     rout_c[p][l*LANE_W +: LANE_W] = bus.InputData[l*LANE_W +: LANE_W];
                  end
               end
            end
         end
      end
   end

   assign bus.Rout1    = rout_c[0];
   assign bus.Rout2    = rout_c[1];
   assign bus.Pending1 = pend_c[0];
   assign bus.Pending2 = pend_c[1];
   assign bus.Busy     = busy_q;
endmodule

// File: tb/tb_vec_regfile_sb.sv
// tb/tb_vec_regfile_sb.sv - self-checking bench for vec_regfile_sb
// Directed table, corner-case sequences and a random run against an array-based model.
module tb_vec_regfile_sb;
   localparam int NR = 8;
   localparam int LN = 4;
   localparam int LW = 32;
   localparam int AW = 5;
   localparam int VW = LN * LW;

   localparam logic [VW-1:0] D1   = 128'h11112222_33334444_55556666_77778888;
   localparam logic [VW-1:0] D2   = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
   localparam logic [VW-1:0] MRG  = 128'h11112222_BBBBBBBB_55556666_DDDDDDDD;
   localparam logic [VW-1:0] FLO  = 128'h00000000_00000000_FFFFFFFF_FFFFFFFF;
   localparam logic [VW-1:0] ONES = {VW{1'b1}};

   logic clk = 1'b0;
   logic rst;

   vec_regfile_sb_if #(.LANES(LN), .LANE_W(LW), .ADDR_W(AW)) bus ();

   vec_regfile_sb #(.NUM_REGS(NR), .LANES(LN), .LANE_W(LW), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [VW-1:0] m_mem  [NR];
   bit            m_pend [NR];
   int            m_left = NR;

   typedef struct {
      logic          we;
      logic [AW-1:0] rd;
      logic [LN-1:0] mask;
      logic [VW-1:0] data;
      logic          ie;
      logic [AW-1:0] ird;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [VW-1:0] e_r1;
      logic [VW-1:0] e_r2;
      logic          e_p1;
      logic          e_p2;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      int a;
      if (rst) begin
         m_left = NR;
         for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
      end else if (m_left > 0) begin
         m_mem[NR - m_left] = '0;
         m_left--;
      end else begin
         a = int'(bus.rd);
         if (bus.WriteEn && a < NR) begin
            for (int l = 0; l < LN; l++)
               if (bus.WriteMask[l]) m_mem[a][l*LW +: LW] = bus.InputData[l*LW +: LW];
            m_pend[a] = 1'b0;
         end
         a = int'(bus.IssueRd);
         if (bus.IssueEn && a < NR) m_pend[a] = 1'b1;
      end
   endtask

   function automatic logic [VW-1:0] exp_rout(input logic [AW-1:0] rs);
      logic [VW-1:0] v;
      int a;
      a = int'(rs);
      if (m_left > 0 || a >= NR) return '0;
      v = m_mem[a];
      if (bus.WriteEn && bus.rd == rs)
         for (int l = 0; l < LN; l++)
            if (bus.WriteMask[l]) v[l*LW +: LW] = bus.InputData[l*LW +: LW];
      return v;
   endfunction

   function automatic logic exp_pend(input logic [AW-1:0] rs);
      int a;
      a = int'(rs);
      if (m_left > 0 || a >= NR) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_rout1"}, bus.Rout1, exp_rout(bus.Rs1));
      chk({tag, "_rout2"}, bus.Rout2, exp_rout(bus.Rs2));
      chk({tag, "_pend1"}, VW'(bus.Pending1), VW'(exp_pend(bus.Rs1)));
      chk({tag, "_pend2"}, VW'(bus.Pending2), VW'(exp_pend(bus.Rs2)));
      chk({tag, "_busy"}, VW'(bus.Busy), VW'(m_left > 0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      bus.WriteEn   = 1'b0;
      bus.rd        = '0;
      bus.WriteMask = '0;
      bus.InputData = '0;
      bus.IssueEn   = 1'b0;
      bus.IssueRd   = '0;
   endtask

   task automatic count_busy(input string tag);
      int n;
      n = 0;
      while (bus.Busy === 1'b1 && n < 20) begin
         #3;
         check_all(tag);
         n++;
         tick();
      end
      chk({tag, "_len"}, VW'(n), VW'(8));
   endtask

   task automatic dump(input string tag, input logic [VW-1:0] e0, input logic [VW-1:0] e1,
                       input logic [VW-1:0] e2, input logic [VW-1:0] e3, input logic [VW-1:0] e4,
                       input logic [VW-1:0] e5, input logic [VW-1:0] e6, input logic [VW-1:0] e7);
      logic [VW-1:0] exp [NR];
      exp = '{e0, e1, e2, e3, e4, e5, e6, e7};
      idle();
      for (int r = 0; r < NR; r++) begin
         bus.Rs1 = AW'(r);
         bus.Rs2 = AW'(NR - 1 - r);
         #1;
         chk($sformatf("%s_reg%0d", tag, r), bus.Rout1, exp[r]);
         chk($sformatf("%s_reg%0d_p2", tag, NR - 1 - r), bus.Rout2, exp[NR - 1 - r]);
      end
   endtask

   initial begin
      for (int r = 0; r < NR; r++) begin
         m_mem[r]  = '0;
         m_pend[r] = 1'b0;
      end
      tbl[0]  = '{1'b1, 5'd3, 4'hF, D1,   1'b0, 5'd0, 5'd3, 5'd0, D1,   '0,   1'b0, 1'b0};
      tbl[1]  = '{1'b1, 5'd3, 4'h5, D2,   1'b0, 5'd0, 5'd3, 5'd3, MRG,  MRG,  1'b0, 1'b0};
      tbl[2]  = '{1'b0, 5'd0, 4'h0, '0,   1'b0, 5'd0, 5'd3, 5'd5, MRG,  '0,   1'b0, 1'b0};
      tbl[3]  = '{1'b1, 5'd5, 4'h3, ONES, 1'b0, 5'd0, 5'd5, 5'd5, FLO,  FLO,  1'b0, 1'b0};
      tbl[4]  = '{1'b0, 5'd0, 4'h0, '0,   1'b0, 5'd0, 5'd5, 5'd3, FLO,  MRG,  1'b0, 1'b0};
      tbl[5]  = '{1'b0, 5'd0, 4'h0, '0,   1'b1, 5'd2, 5'd2, 5'd2, '0,   '0,   1'b0, 1'b0};
      tbl[6]  = '{1'b1, 5'd2, 4'h0, ONES, 1'b1, 5'd2, 5'd2, 5'd4, '0,   '0,   1'b1, 1'b0};
      tbl[7]  = '{1'b0, 5'd0, 4'h0, '0,   1'b0, 5'd0, 5'd2, 5'd2, '0,   '0,   1'b1, 1'b1};
      tbl[8]  = '{1'b1, 5'd2, 4'hF, D2,   1'b0, 5'd0, 5'd2, 5'd3, D2,   MRG,  1'b1, 1'b0};
      tbl[9]  = '{1'b0, 5'd0, 4'h0, '0,   1'b0, 5'd0, 5'd2, 5'd3, D2,   MRG,  1'b0, 1'b0};
      tbl[10] = '{1'b1, 5'd9, 4'hF, ONES, 1'b0, 5'd0, 5'd9, 5'd9, '0,   '0,   1'b0, 1'b0};
      tbl[11] = '{1'b0, 5'd0, 4'h0, '0,   1'b1, 5'd9, 5'd9, 5'd1, '0,   '0,   1'b0, 1'b0};

      rst = 1'b1;
      idle();
      bus.Rs1 = 5'd0;
      bus.Rs2 = 5'd1;
      tick();
      chk("rst_busy", VW'(bus.Busy), VW'(1));
      chk("rst_pend1", VW'(bus.Pending1), '0);
      chk("rst_pend2", VW'(bus.Pending2), '0);
      chk("rst_rout1", bus.Rout1, '0);
      chk("rst_rout2", bus.Rout2, '0);
      rst = 1'b0;
      count_busy("clr0");

      for (int r = 0; r < NR; r++) begin
         bus.WriteEn   = 1'b1;
         bus.rd        = AW'(r);
         bus.WriteMask = 4'hF;
         bus.InputData = ONES;
         tick();
      end
      dump("preload", ONES, ONES, ONES, ONES, ONES, ONES, ONES, ONES);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_busy("clr1");
      dump("cleared", '0, '0, '0, '0, '0, '0, '0, '0);

      for (int i = 0; i < 12; i++) begin
         bus.WriteEn   = tbl[i].we;
         bus.rd        = tbl[i].rd;
         bus.WriteMask = tbl[i].mask;
         bus.InputData = tbl[i].data;
         bus.IssueEn   = tbl[i].ie;
         bus.IssueRd   = tbl[i].ird;
         bus.Rs1       = tbl[i].rs1;
         bus.Rs2       = tbl[i].rs2;
         #3;
         chk($sformatf("tbl%0d_rout1", i), bus.Rout1, tbl[i].e_r1);
         chk($sformatf("tbl%0d_rout2", i), bus.Rout2, tbl[i].e_r2);
         chk($sformatf("tbl%0d_pend1", i), VW'(bus.Pending1), VW'(tbl[i].e_p1));
         chk($sformatf("tbl%0d_pend2", i), VW'(bus.Pending2), VW'(tbl[i].e_p2));
         check_all($sformatf("tbl%0d_model", i));
         tick();
      end
      dump("after_tbl", '0, '0, D2, MRG, '0, FLO, '0, '0);

      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #3;
         check_all("midclr");
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.WriteEn   = 1'b1;
      bus.rd        = 5'd1;
      bus.WriteMask = 4'hF;
      bus.InputData = ONES;
      bus.IssueEn   = 1'b1;
      bus.IssueRd   = 5'd1;
      bus.Rs1       = 5'd1;
      bus.Rs2       = 5'd0;
      count_busy("clr2");
      idle();
      #1;
      chk("busy_wr_rout1", bus.Rout1, '0);
      chk("busy_iss_pend1", VW'(bus.Pending1), '0);

      for (int c = 0; c < 600; c++) begin
         rst           = ($urandom_range(0, 79) == 0);
         bus.WriteEn   = ($urandom_range(0, 2) != 0);
         bus.rd        = AW'($urandom_range(0, 9));
         bus.WriteMask = LN'($urandom());
         bus.InputData = {$urandom(), $urandom(), $urandom(), $urandom()};
         bus.IssueEn   = ($urandom_range(0, 2) == 0);
         bus.IssueRd   = AW'($urandom_range(0, 9));
         bus.Rs1       = ($urandom_range(0, 3) == 0) ? bus.rd : AW'($urandom_range(0, 9));
         bus.Rs2       = AW'($urandom_range(0, 9));
         #3;
         check_all($sformatf("rnd%0d", c));
         tick();
      end
      rst = 1'b0;
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vec_regfile_sb.md
Name: vec_regfile_sb

Overview:
- Parametrised vector register file for the Decode stage; next generation of the 8x128 vector register file.
- Generalised to configurable register count, lane count and lane width.
- Adds per-lane write masking, same-cycle write-to-read forwarding, a sequenced clear after reset, and a per-register pending scoreboard for hazard detection.
- Sits between the decoder, which supplies Rs1/Rs2/rd/issue, and writeback, which supplies WriteEn/InputData.

Parameters:
NUM_REGS, 8, number of vector registers
LANES, 4, lanes per vector
LANE_W, 32, bits per lane; vector width VW = LANES*LANE_W (128 at defaults)
ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
WriteEn  in  1  writeback strobe
rd  in  ADDR_W  writeback destination register
WriteMask  in  LANES  per-lane write enable; bit i covers lane i = bits [i*LANE_W +: LANE_W]
InputData  in  VW  writeback data
IssueEn  in  1  decoder issues an instruction that will write IssueRd
IssueRd  in  ADDR_W  destination register of the issued instruction
Rs1  in  ADDR_W  read address, port 1
Rs2  in  ADDR_W  read address, port 2
Rout1  out  VW  read data, port 1
Rout2  out  VW  read data, port 2
Pending1  out  1  Rs1 has an outstanding write
Pending2  out  1  Rs2 has an outstanding write
Busy  out  1  clear sequence in progress; decoder must stall

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- FSM states: CLEAR, READY.
- rst=1 at a clock edge:
  - state<=CLEAR, clear index<=0, all pending bits<=0.
  - Register contents are not touched on that edge.
- CLEAR:
  - Each cycle with rst=0: reg[idx]<=0, idx<=idx+1.
  - When idx==NUM_REGS-1 the clear completes, state<=READY.
  - Takes exactly NUM_REGS cycles after rst deasserts.
- Busy=1 in CLEAR, 0 in READY. Busy=1 from the first edge with rst=1 until NUM_REGS edges after rst falls.
- rst asserted mid-clear restarts the sequence at idx 0.
- While Busy=1:
  - WriteEn and IssueEn are ignored.
  - Rout1/Rout2 = 0; Pending1/Pending2 = 0.
- Write (READY, WriteEn=1, rd<NUM_REGS): on the edge, lane i of reg[rd] <= lane i of InputData for each WriteMask[i]=1; other lanes keep their value.
- WriteMask=0 is a legal no-op for data, but still clears pending.
- Read (combinational, zero latency):
  - RoutN = reg[RsN] with forwarding.
  - If WriteEn=1 and rd==RsN in READY, each lane with WriteMask[i]=1 shows InputData lane i in the same cycle; other lanes show stored data.
  - Rs1==Rs2 forwards to both ports.
- Out-of-range addresses (>=NUM_REGS):
  - Reads return 0 with Pending=0.
  - Writes and issues are ignored.
- Scoreboard (READY):
  - pending[IssueRd]<=1 on IssueEn.
  - pending[rd]<=0 on WriteEn.
  - Same register in the same cycle: issue wins, pending stays 1 (new producer).
  - Different registers: both updates apply.
  - PendingN = pending[RsN], registered state only; a same-cycle write does not clear it combinationally.
- Output values after reset: Busy=1, Pending1=Pending2=0, Rout1=Rout2=0.

Test Plan:
- Pulse rst 1 cycle with regs pre-loaded with 0xFF..FF -> Busy=1 for exactly 8 cycles after rst falls; afterwards Rs1=0..7 all read 0.
- READY: write rd=3, mask=4'b1111, data=0x11112222_33334444_55556666_77778888; next cycle write rd=3, mask=4'b0101, data=0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> Rout1(Rs1=3)=0x11112222_BBBBBBBB_55556666_DDDDDDDD.
- Forwarding: reg5=0, WriteEn=1, rd=5, mask=4'b0011, data=all 0xF, Rs1=Rs2=5 in the same cycle -> Rout1=Rout2=0x00000000_00000000_FFFFFFFF_FFFFFFFF that cycle, still stored next cycle.
- Scoreboard:
  - IssueEn, IssueRd=2 -> Pending1(Rs1=2)=1 next cycle.
  - Write rd=2 while issuing IssueRd=2 -> Pending stays 1.
  - Write rd=2 alone -> Pending1=0 next cycle.
- Out of range: WriteEn, rd=9, Rs1=9 -> Rout1=0, Pending1=0, no register changes (dump all 8).
- rst reasserted at clear cycle 4, then released -> Busy stays high for 8 more cycles; a WriteEn to rd=1 during Busy is ignored and reg1 reads 0 afterwards.
